// File: rtl/clk_divider_if.sv
// Control/status bundle between the clock divider and its controller.
// The controller drives run and ratio requests; the divider returns status and clock.
interface clk_divider_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             div_busy;
  logic             div_err;
  logic [DIV_W-1:0] cur_div;
  logic             clk_out;
  logic             clk_rise;

  modport master (
    output en, div_val, div_load,
    input  div_busy, div_err, cur_div, clk_out, clk_rise
  );

  modport slave (
    input  en, div_val, div_load,
    output div_busy, div_err, cur_div, clk_out, clk_rise
  );
endinterface

// File: rtl/clk_divider.sv
// Programmable integer clock divider with glitch-free start/stop and ratio-change handshake.
// Optional macro CLK_DIV_ODD50_EN adds a negedge flop for 50% duty on odd ratios.
module clk_divider #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic         clk_in,
  input  logic         rst,
  clk_divider_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] cur_div, cur_div_nxt;
  logic [DIV_W-1:0] pending, pending_nxt;
  logic             busy, busy_nxt;
  logic             err_q, err_nxt;
  logic             pos_q, pos_nxt;
  logic             rise_q, rise_nxt;
  logic             apply;
  logic             at_wrap;
  logic [DIV_W:0]   high_len;

  // Extra bit keeps ceil(N/2) exact when N is the maximum ratio.
`ifdef CLK_DIV_ODD50_EN
  assign high_len = {1'b0, cur_div} >> 1;
`else
  assign high_len = ({1'b0, cur_div} + 1'b1) >> 1;
`endif

  assign at_wrap = (cnt == cur_div - 1'b1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cur_div_nxt = cur_div;
    pending_nxt = pending;
    busy_nxt    = busy;
    err_nxt     = 1'b0;
    pos_nxt     = pos_q;
    rise_nxt    = 1'b0;
    apply       = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        pos_nxt = 1'b0;
        apply   = busy;
        if (bus.en) begin
          state_nxt = RUN;
          pos_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (at_wrap) begin
          // Period boundary: the only place ratio changes and stops take effect.
          apply   = busy;
          cnt_nxt = '0;
          if (bus.en) begin
            pos_nxt  = 1'b1;
            rise_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            pos_nxt   = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
          pos_nxt = ({1'b0, cnt_nxt} < high_len);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (apply) begin
      cur_div_nxt = pending;
      busy_nxt    = 1'b0;
    end

    // While busy, a new strobe is dropped silently; the first pending ratio wins.
    if (bus.div_load && !busy) begin
      if (bus.div_val >= DIV_W'(2)) begin
        pending_nxt = bus.div_val;
        busy_nxt    = 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_div <= DIV_W'(DIV_RESET);
      pending <= '0;
      busy    <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_div <= cur_div_nxt;
      pending <= pending_nxt;
      busy    <= busy_nxt;
      err_q   <= err_nxt;
      pos_q   <= pos_nxt;
      rise_q  <= rise_nxt;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic neg_q;

  // Half-cycle-delayed copy of the high phase stretches odd ratios to exact 50% duty.
  always_ff @(negedge clk_in) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= pos_q & cur_div[0];
  end

  assign bus.clk_out = pos_q | neg_q;
`else
  assign bus.clk_out = pos_q;
`endif

  assign bus.clk_rise = rise_q;
  assign bus.cur_div  = cur_div;
  assign bus.div_busy = busy;
  assign bus.div_err  = err_q;

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: directed scenarios plus random traffic,
// compared every cycle against a queue-of-samples period model.
module tb_clk_divider;

  localparam int DIV_W     = 8;
  localparam int DIV_RESET = 2;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             en     = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_val  = '0;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  clk_divider_if #(.DIV_W(DIV_W)) bus ();

  assign bus.en       = en;
  assign bus.div_load = div_load;
  assign bus.div_val  = div_val;

  clk_divider #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference: each started period is a list of N samples (high for the first
  // ceil(N/2), rise on the first); the queue front is the current output.
  typedef struct packed {logic hi; logic rise;} samp_t;
  samp_t q[$];
  int    m_cur  = DIV_RESET;
  int    m_pend = 0;
  logic  m_busy = 1'b0;
  logic  m_err  = 1'b0;

  function automatic void push_period(int n);
    for (int i = 0; i < n; i++) begin
      samp_t s;
      s.hi   = (i < (n + 1) / 2);
      s.rise = (i == 0);
      q.push_back(s);
    end
  endfunction

  function automatic void model_update();
    logic old_busy;
    if (rst) begin
      q.delete();
      m_cur  = DIV_RESET;
      m_busy = 1'b0;
      m_err  = 1'b0;
    end else begin
      old_busy = m_busy;
      if (q.size() > 0) void'(q.pop_front());
      if (q.size() == 0) begin
        if (old_busy) begin
          m_cur  = m_pend;
          m_busy = 1'b0;
        end
        if (en) push_period(m_cur);
      end
      m_err = div_load && !old_busy && (int'(div_val) < 2);
      if (div_load && !old_busy && int'(div_val) >= 2) begin
        m_pend = int'(div_val);
        m_busy = 1'b1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cycle, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_update();
    cycle++;
    #1;
    check("clk_out",  32'(bus.clk_out),  32'(q.size() > 0 ? q[0].hi   : 1'b0));
    check("clk_rise", 32'(bus.clk_rise), 32'(q.size() > 0 ? q[0].rise : 1'b0));
    check("cur_div",  32'(bus.cur_div),  32'(m_cur));
    check("div_busy", 32'(bus.div_busy), 32'(m_busy));
    check("div_err",  32'(bus.div_err),  32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input int val);
    div_val  = DIV_W'(val);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  // Advance until the model sits at a given offset from the end of a period.
  task automatic align(input string tag, input int remaining);
    for (int i = 0; i < 600 && q.size() != remaining; i++) step();
    check(tag, 32'(q.size()), 32'(remaining));
  endtask

  initial begin
    int last_rise;
    int prev_rise;

    // Reset state
    run(2);
    rst = 1'b0;
    run(2);

    // Start at DIV_RESET: first high one cycle after en
    en = 1'b1;
    run(10);

    // Ratio change to 5 while running
    pulse_load(5);
    run(15);

    // Ratio 4, then stop mid-period and restart
    pulse_load(4);
    run(10);
    align("align_stop", 3);
    en = 1'b0;
    run(8);
    en = 1'b1;
    run(6);

    // Rejected load, then a second load while busy is ignored
    pulse_load(1);
    run(2);
    pulse_load(4);
    pulse_load(6);
    run(12);

    // Reset in the middle of the high phase of an N=8 period
    pulse_load(8);
    run(10);
    align("align_rst", 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(8);

    // Maximum ratio: exact rise spacing
    pulse_load(255);
    last_rise = -1;
    prev_rise = -1;
    for (int i = 0; i < 900; i++) begin
      step();
      if (bus.clk_rise === 1'b1 && bus.cur_div === 8'd255) begin
        prev_rise = last_rise;
        last_rise = cycle;
      end
    end
    check("rise_gap_255", 32'(last_rise - prev_rise), 32'd255);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 15) != 0);
      div_load = ($urandom_range(0, 19) == 0);
      div_val  = DIV_W'($urandom_range(0, 9));
      rst      = ($urandom_range(0, 399) == 0);
      step();
    end
    rst      = 1'b0;
    div_load = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_divider.md
Name: clk_divider

Overview:
Programmable integer clock divider that sits directly upstream of clk_buffer and drives its clk_in.
- Divides the root clock by N (N >= 2).
- Supports glitch-free start/stop and a handshake for changing N on the fly.
- Ratio changes and stops take effect only at output period boundaries, so clk_buffer never sees a runt pulse.

Parameters:
- DIV_W, 8, width of the divide-ratio field.
- DIV_RESET, 2, divide ratio loaded at reset (must be >= 2).

Ports:
- clk_in  input  1  root clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run request for the divided clock.
- div_val  input  DIV_W  requested divide ratio N.
- div_load  input  1  one-cycle strobe requesting a load of div_val.
- div_busy  output  1  load accepted but not yet applied.
- div_err  output  1  one-cycle pulse when a load is rejected.
- cur_div  output  DIV_W  divide ratio currently in effect.
- clk_out  output  1  divided clock; feeds clk_buffer.clk_in.
- clk_rise  output  1  one clk_in-cycle pulse, coincident with each clk_out low-to-high transition.

Behaviour:
- Notation: N = cur_div; H = ceil(N/2), the high-phase length.
- Reset, synchronous, sampled at the clk_in posedge:
  - state=IDLE, cnt=0, clk_out=0, clk_rise=0.
  - cur_div=DIV_RESET, div_busy=0, div_err=0, pending register cleared.
  - Reset mid-period aborts that period immediately; clk_out goes low the following cycle.
- All outputs are registered. No combinational path from inputs to outputs (except as noted under Optional Feature).
- State IDLE:
  - clk_out=0, cnt held at 0.
  - If en=1: next cycle go to RUN with cnt=0, clk_out=1, clk_rise=1.
  - Latency is one clk_in cycle from en=1 to the first clk_out high.
- State RUN:
  - cnt counts 0..N-1 and wraps to 0.
  - clk_out=1 while cnt<H, and 0 while H<=cnt<=N-1.
  - clk_rise=1 only in the cycle where cnt==0.
- Stop:
  - en is sampled only at cnt==N-1, the period boundary.
  - If en=0 there, go to IDLE. clk_out stays low and no partial period is ever emitted.
  - en toggling inside a period has no effect.
- Load handshake:
  - div_load=1 with div_busy=0 and div_val>=2: capture div_val into pending and set div_busy=1 the next cycle.
  - div_load=1 with div_val<2: reject. div_err=1 for one cycle, no state change.
  - div_load=1 while div_busy=1: ignored silently. The first pending value wins; no div_err.
  - Apply in RUN: at the boundary cycle (cnt==N-1 transitioning to 0), cur_div takes the pending value. The new period uses the new N. div_busy clears in that same cycle.
  - Apply in IDLE: the pending value is applied on the cycle after capture, and div_busy clears then.
  - Simultaneous boundary and stop: the load is applied and the block enters IDLE. The next start uses the new N.
  - Simultaneous div_load and apply of a previous load: the new strobe is ignored, because div_busy is still 1 in that cycle.
- Width rule: cnt is DIV_W bits. N=2^DIV_W-1 is the maximum and must not overflow cnt.

Optional Feature:
- Macro: CLK_DIV_ODD50_EN.
- Defined:
  - Adds one negedge-clk_in flop (reset synchronously to 0 on rst) holding a half-cycle-delayed copy of the posedge high phase.
  - For odd N, clk_out = posedge_q OR negedge_q, giving exactly N/2 cycles high (50% duty).
  - For even N, negedge_q is forced to 0 and behaviour is identical to the base design.
  - clk_rise timing is unchanged.
- Undefined:
  - No negedge logic.
  - Odd N gives H=ceil(N/2) cycles high and floor(N/2) cycles low.

Test Plan:
- Reset, then en=1 with DIV_RESET=2 -> first clk_out=1 one cycle after en. clk_out toggles every clk_in cycle (period 20ns at 100MHz). clk_rise pulses every 2 cycles.
- div_val=5, div_load pulse while running at N=2 -> div_busy=1 until the next wrap, then cur_div=5. Period is 5 cycles: high 3/low 2 without the macro, high 2.5/low 2.5 with CLK_DIV_ODD50_EN.
- en=0 at cnt=1 with N=4 -> clk_out completes its low phase (cnt 2,3) and then stays 0. No high pulse shorter than 2 cycles. Re-assert en -> high one cycle later.
- div_val=1, div_load pulse -> div_err=1 for exactly one cycle; cur_div and div_busy unchanged. A second div_load with div_val=6 while busy with 4 -> ignored, and 4 is applied.
- rst asserted at cnt=2 with N=8 (clk_out high) -> next cycle clk_out=0, cur_div=DIV_RESET, div_busy=0. Restart behaves as after power-up.
- DIV_W=8, div_val=255 -> 255-cycle period (high 128/low 127 without the macro). No counter wrap error and clk_rise spacing is exactly 255 cycles.
